lsu_align_split: RTL

- Load/store front-end that sits directly upstream of the data memory, between the execute stage and the memory.
- Aligned accesses pass straight through to the memory with zero added latency.
- Misaligned halfword/word accesses are split into sequential byte accesses while the pipeline is stalled.
- For split loads, the block assembles the bytes and sign/zero-extends the result before returning it to writeback.

---
 rtl/lsu_align_split.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/lsu_align_split.sv
// Load/store front-end: aligned accesses pass straight through to data memory,
// misaligned halfword/word accesses are split into byte accesses while stalled.
module lsu_align_split #(
    parameter bit ALLOW_MISALIGNED = 1'b1,
    parameter int ADDR_W           = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_mask,
    input  logic              req_wr,
    input  logic              req_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [2:0]        mem_mask,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       resp_rdata,
    output logic              resp_valid,
    output logic              stall,
    output logic              misalign_err
);

    typedef enum logic [1:0] {IDLE, SPLIT, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base_addr;
    logic [31:0]       base_wdata;
    logic [2:0]        base_mask;
    logic              base_wr;
    logic [2:0]        n_bytes;
    logic [2:0]        cnt;
    logic [31:0]       asm_buf;
    logic              is_half, is_word, misaligned;

    function automatic logic [31:0] extend(input logic [31:0] b, input logic [2:0] m);
        case (m)
            3'b001:  extend = {{16{b[15]}}, b[15:0]};
            3'b101:  extend = {16'h0000, b[15:0]};
            default: extend = b;
        endcase
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [2:0] idx);
        byte_sel = w[{idx[1:0], 3'b000} +: 8];
    endfunction

    assign is_half    = (req_mask == 3'b001) || (req_mask == 3'b101);
    assign is_word    = (req_mask == 3'b010);
    assign misaligned = req_valid && (req_wr || req_rd) &&
                        ((is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00)));

    always_comb begin
        state_nxt    = state;
        mem_addr     = req_addr;
        mem_wdata    = req_wdata;
        mem_mask     = req_mask;
        mem_wr_en    = 1'b0;
        mem_rd_en    = 1'b0;
        resp_rdata   = mem_rdata;
        resp_valid   = 1'b0;
        stall        = 1'b0;
        misalign_err = 1'b0;
        case (state)
            IDLE: begin
                if (misaligned) begin
                    if (ALLOW_MISALIGNED) begin
                        stall     = 1'b1;
                        state_nxt = SPLIT;
                    end else begin
                        misalign_err = 1'b1;
                    end
                end else begin
                    mem_wr_en  = req_valid && req_wr;
                    mem_rd_en  = req_valid && req_rd && !req_wr;
                    resp_valid = req_valid && req_rd && !req_wr;
                end
            end
            SPLIT: begin
                stall    = 1'b1;
                mem_addr = base_addr + ADDR_W'(cnt);
                if (base_wr) begin
                    mem_mask  = 3'b000;
                    mem_wdata = {4{byte_sel(base_wdata, cnt)}};
                    mem_wr_en = 1'b1;
                end else begin
                    mem_mask  = 3'b100;
                    mem_rd_en = 1'b1;
                end
                if (cnt == n_bytes - 3'd1)
                    state_nxt = DONE;
            end
            DONE: begin
                mem_addr   = base_addr;
                mem_wdata  = base_wdata;
                mem_mask   = base_mask;
                resp_valid = !base_wr;
                resp_rdata = extend(asm_buf, base_mask);
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // No memory traffic or response while reset is held, so a reset that
        // lands mid-split stops the store at the bytes already written.
        if (rst) begin
            mem_wr_en    = 1'b0;
            mem_rd_en    = 1'b0;
            resp_valid   = 1'b0;
            misalign_err = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            n_bytes    <= 3'd0;
            asm_buf    <= 32'h0;
            base_addr  <= '0;
            base_wdata <= 32'h0;
            base_mask  <= 3'b000;
            base_wr    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (misaligned && ALLOW_MISALIGNED) begin
                        base_addr  <= req_addr;
                        base_wdata <= req_wdata;
                        base_mask  <= req_mask;
                        base_wr    <= req_wr;
                        n_bytes    <= is_word ? 3'd4 : 3'd2;
                        cnt        <= 3'd0;
                    end
                end
                SPLIT: begin
                    cnt <= cnt + 3'd1;
                    if (!base_wr)
                        asm_buf[{cnt[1:0], 3'b000} +: 8] <= mem_rdata[7:0];
                end
                default: ;
            endcase
        end
    end

endmodule
